rv_exec_unit: RTL and testbench



---
 rtl/rv_pkg.sv | 39 +++
 rtl/rv_exec_unit_if.sv | 22 ++
 rtl/alu.sv | 27 ++
 rtl/control.sv | 132 +++++++++++++
 rtl/reg_file.sv | 33 +++
 rtl/rv_exec_unit.sv | 58 +++++
 tb/tb_rv_exec_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/rv_pkg.sv
// Shared constants for the RV32I-subset execute slice: opcodes, funct3 codes and ALU ops.
package rv_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  // Arithmetic / logic funct3 (shared by OP and OP-IMM)
  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3Srl    = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  // Memory / control-flow funct3
  localparam logic [2:0] F3Sw     = 3'b010;
  localparam logic [2:0] F3Beq    = 3'b000;
  localparam logic [2:0] F3Bne    = 3'b001;
  localparam logic [2:0] F3Blt    = 3'b100;
  localparam logic [2:0] F3Bge    = 3'b101;
  localparam logic [2:0] F3Jalr   = 3'b000;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluXor = 3'd4,
    AluSll = 3'd5,
    AluSrl = 3'd6,
    AluSlt = 3'd7
  } alu_op_e;

endpackage

// File: rtl/rv_exec_unit_if.sv
// Core <-> execute-slice bus: instruction/PC in, next-PC decision and store request out.
interface rv_exec_unit_if;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;

  // Core side: owns PC and fetch.
  modport master (
    output instr, pc,
    input  branch_taken, branch_target, mem_addr, mem_data, mem_we
  );

  // Execute slice side.
  modport slave (
    input  instr, pc,
    output branch_taken, branch_target, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/alu.sv
// Pure combinational 32-bit ALU; shifts use b[4:0], arithmetic wraps mod 2^32.
module alu
  import rv_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  // Operation select
  always_comb begin
    result = '0;
    unique case (op)
      AluAdd: result = a + b;
      AluSub: result = a - b;
      AluAnd: result = a & b;
      AluOr:  result = a | b;
      AluXor: result = a ^ b;
      AluSll: result = a << b[4:0];
      AluSrl: result = a >> b[4:0];
      AluSlt: result = {31'b0, $signed(a) < $signed(b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/control.sv
// Instruction decode, immediate generation and branch decision from the ALU result.
module control
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] alu_result,
  output alu_op_e     alu_op,
  output logic [31:0] imm32,
  output logic        has_imm,
  output logic        rf_we,
  output logic        mem_we,
  output logic        lr,
  output logic        direct_branch,
  output logic        branch_taken
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Decode: defaults describe the NOP, each supported encoding overrides them
  always_comb begin
    alu_op        = AluAdd;
    imm32         = '0;
    has_imm       = 1'b1;
    rf_we         = 1'b0;
    mem_we        = 1'b0;
    lr            = 1'b0;
    direct_branch = 1'b0;
    case (opcode)
      OpcOp: begin
        has_imm = 1'b0;
        rf_we   = 1'b1;
        case (funct3)
          F3AddSub: alu_op = instr[30] ? AluSub : AluAdd;
          F3Sll:    alu_op = AluSll;
          F3Slt:    alu_op = AluSlt;
          F3Xor:    alu_op = AluXor;
          F3Srl:    alu_op = AluSrl;
          F3Or:     alu_op = AluOr;
          F3And:    alu_op = AluAnd;
          default: begin
            has_imm = 1'b1;
            rf_we   = 1'b0;
          end
        endcase
      end
      OpcOpImm: begin
        imm32 = imm_i;
        rf_we = 1'b1;
        case (funct3)
          F3AddSub: alu_op = AluAdd;
          F3Sll:    alu_op = AluSll;
          F3Slt:    alu_op = AluSlt;
          F3Xor:    alu_op = AluXor;
          F3Srl:    alu_op = AluSrl;
          F3Or:     alu_op = AluOr;
          F3And:    alu_op = AluAnd;
          default: begin
            imm32 = '0;
            rf_we = 1'b0;
          end
        endcase
      end
      OpcStore: begin
        if (funct3 == F3Sw) begin
          imm32  = imm_s;
          mem_we = 1'b1;
        end
      end
      OpcBranch: begin
        case (funct3)
          F3Beq, F3Bne: begin
            alu_op        = AluSub;
            has_imm       = 1'b0;
            imm32         = imm_b;
            direct_branch = 1'b1;
          end
          F3Blt, F3Bge: begin
            alu_op        = AluSlt;
            has_imm       = 1'b0;
            imm32         = imm_b;
            direct_branch = 1'b1;
          end
          default: ;
        endcase
      end
      OpcJal: begin
        imm32         = imm_j;
        direct_branch = 1'b1;
        lr            = 1'b1;
        rf_we         = 1'b1;
      end
      OpcJalr: begin
        if (funct3 == F3Jalr) begin
          imm32 = imm_i;
          lr    = 1'b1;
          rf_we = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Branch decision, kept apart from decode so the ALU feedback is not a combinational loop
  always_comb begin
    branch_taken = 1'b0;
    case (opcode)
      OpcBranch: begin
        case (funct3)
          F3Beq:   branch_taken = (alu_result == 32'd0);
          F3Bne:   branch_taken = (alu_result != 32'd0);
          F3Blt:   branch_taken = alu_result[0];
          F3Bge:   branch_taken = ~alu_result[0];
          default: branch_taken = 1'b0;
        endcase
      end
      OpcJal:  branch_taken = 1'b1;
      OpcJalr: branch_taken = (funct3 == F3Jalr);
      default: branch_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// 32x32 register file: two async read ports, one write port, x0 hardwired to zero, no bypass.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  // Storage; async reset clears every entry and holds writes off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: old value during a write cycle
  always_comb begin
    rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
    rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];
  end

endmodule

// File: rtl/rv_exec_unit.sv
// Execute/writeback slice: wiring of decode, ALU and register file plus target/link muxing.
module rv_exec_unit
  import rv_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rv_exec_unit_if.slave  bus
);

  alu_op_e     alu_op;
  logic [31:0] imm32, rs1_data, rs2_data, src_b, alu_result, wb_data, pc_plus4;
  logic        has_imm, rf_we, mem_we, lr, direct_branch, branch_taken;

  control u_control (
    .instr         (bus.instr),
    .alu_result    (alu_result),
    .alu_op        (alu_op),
    .imm32         (imm32),
    .has_imm       (has_imm),
    .rf_we         (rf_we),
    .mem_we        (mem_we),
    .lr            (lr),
    .direct_branch (direct_branch),
    .branch_taken  (branch_taken)
  );

  reg_file u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (bus.instr[19:15]),
    .raddr_b (bus.instr[24:20]),
    .rdata_a (rs1_data),
    .rdata_b (rs2_data),
    .we      (rf_we),
    .waddr   (bus.instr[11:7]),
    .wdata   (wb_data)
  );

  alu u_alu (
    .op     (alu_op),
    .a      (rs1_data),
    .b      (src_b),
    .result (alu_result)
  );

  // Operand, writeback and next-PC muxes; JALR target drops bit 0
  always_comb begin
    pc_plus4          = bus.pc + 32'd4;
    src_b             = has_imm ? imm32 : rs2_data;
    wb_data           = lr ? pc_plus4 : alu_result;
    bus.branch_target = direct_branch ? (bus.pc + imm32) : {alu_result[31:1], 1'b0};
    bus.branch_taken  = branch_taken;
    bus.mem_addr      = alu_result;
    bus.mem_data      = rs2_data;
    bus.mem_we        = mem_we;
  end

endmodule

// File: tb/tb_rv_exec_unit.sv
// Self-checking bench for rv_exec_unit: directed plan cases plus randomized instructions
// against an instruction-level reference model.
module tb_rv_exec_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rv_exec_unit_if bus ();

  rv_exec_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic        chk_target;
    logic [31:0] addr;
    logic        chk_addr;
    logic [31:0] data;
    logic        we;
    logic        rf_we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } exp_t;

  logic [31:0] regs [32];

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic f7b5, input int rs2, input int rs1,
                                        input int f3, input int rd);
    logic [31:0] w;
    w = {1'b0, f7b5, 5'b0, rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    return w;
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] im;
    im = imm;
    return {im[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] im;
    im = imm;
    return {im[11:5], rs2[4:0], rs1[4:0], 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                        input int f3);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] im;
    im = imm;
    return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'b1101111};
  endfunction

  // ---------------- reference model ----------------
  function automatic exp_t model_eval(input logic [31:0] ins, input logic [31:0] pcv);
    exp_t        e;
    logic [31:0] a, b, ii, is, ib, ij, r;
    int          f3;
    logic        ok;
    e  = '0;
    a  = (rst || ins[19:15] == 0) ? 32'd0 : regs[ins[19:15]];
    b  = (rst || ins[24:20] == 0) ? 32'd0 : regs[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    f3 = int'(ins[14:12]);
    e.data = b;
    e.rd   = ins[11:7];
    r  = '0;
    ok = 1'b1;
    case (ins[6:0])
      7'b0110011, 7'b0010011: begin
        logic [31:0] y;
        y = (ins[6:0] == 7'b0110011) ? b : ii;
        case (f3)
          0: r = (ins[6:0] == 7'b0110011 && ins[30]) ? a - y : a + y;
          1: r = a << y[4:0];
          2: r = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
          4: r = a ^ y;
          5: r = a >> y[4:0];
          6: r = a | y;
          7: r = a & y;
          default: ok = 1'b0;
        endcase
        if (ok) begin
          e.rf_we = 1'b1; e.wdata = r; e.addr = r; e.chk_addr = 1'b1;
        end
      end
      7'b0100011: if (f3 == 2) begin
        e.we = 1'b1; e.addr = a + is; e.chk_addr = 1'b1;
      end
      7'b1100011: begin
        e.target = pcv + ib;
        case (f3)
          0: begin e.taken = (a == b); e.addr = a - b; end
          1: begin e.taken = (a != b); e.addr = a - b; end
          4: begin e.taken = ($signed(a) < $signed(b)); e.addr = {31'b0, e.taken}; end
          5: begin e.taken = !($signed(a) < $signed(b)); e.addr = {31'b0, !e.taken}; end
          default: ok = 1'b0;
        endcase
        e.chk_target = ok;
        e.chk_addr   = ok;
      end
      7'b1101111: begin
        e.taken = 1'b1; e.target = pcv + ij; e.chk_target = 1'b1;
        e.rf_we = 1'b1; e.wdata = pcv + 4;
      end
      7'b1100111: if (f3 == 0) begin
        e.taken = 1'b1; e.target = (a + ii) & 32'hFFFF_FFFE; e.chk_target = 1'b1;
        e.addr = a + ii; e.chk_addr = 1'b1;
        e.rf_we = 1'b1; e.wdata = pcv + 4;
      end
      default: ;
    endcase
    return e;
  endfunction

  // ---------------- drivers (no checking) ----------------
  task automatic apply(input logic [31:0] ins, input logic [31:0] pcv);
    bus.instr = ins;
    bus.pc    = pcv;
    #1;
  endtask

  // One rising edge; model commits the write the DUT should perform.
  task automatic tick();
    exp_t e;
    e = model_eval(bus.instr, bus.pc);
    @(posedge clk);
    if (!rst && e.rf_we && e.rd != 0) regs[e.rd] = e.wdata;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic val);
    rst = val;
    if (val) for (int i = 0; i < 32; i++) regs[i] = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(1'b1);
    @(negedge clk);
    apply(enc_s(0, 9, 0), 32'h0);
    checks++;
    if (bus.mem_data !== 32'd0) begin
      failures++; $display("FAIL reset_read: got %h want %h", bus.mem_data, 32'd0);
    end
    apply(enc_s(12'h123, 3, 4), 32'h0);
    checks++;
    if (bus.mem_addr !== 32'h123 || bus.mem_we !== 1'b1) begin
      failures++; $display("FAIL reset_sw_addr: got %h/%b want 00000123/1", bus.mem_addr, bus.mem_we);
    end
    apply(enc_b(16, 2, 1, 0), 32'h200);
    checks++;
    if (bus.branch_taken !== 1'b1 || bus.branch_target !== 32'h210) begin
      failures++;
      $display("FAIL reset_beq: got %b/%h want 1/00000210", bus.branch_taken, bus.branch_target);
    end
    apply(enc_i(5, 0, 0, 1, 7'b0010011), 32'h0);
    tick();  // edge inside reset: write suppressed
    do_reset(1'b0);
    apply(enc_s(0, 1, 0), 32'h0);
    checks++;
    if (bus.mem_data !== 32'd0) begin
      failures++; $display("FAIL reset_write_suppressed: got %h want 0", bus.mem_data);
    end
  endtask

  task automatic test_alu_plan();
    apply(enc_i(5, 0, 0, 1, 7'b0010011), 32'h0); tick();
    apply(enc_i(-3, 0, 0, 2, 7'b0010011), 32'h4); tick();
    apply(enc_r(1'b0, 2, 1, 0, 3), 32'h8);
    checks++;
    if (bus.mem_addr !== 32'd2) begin
      failures++; $display("FAIL add_x1_x2: got %h want 2", bus.mem_addr);
    end
    tick();
    apply(enc_r(1'b1, 2, 1, 0, 4), 32'hC);
    checks++;
    if (bus.mem_addr !== 32'd8) begin
      failures++; $display("FAIL sub_x1_x2: got %h want 8", bus.mem_addr);
    end
    tick();
    apply(enc_i(7, 0, 0, 0, 7'b0010011), 32'h10); tick();
    apply(enc_s(0, 0, 0), 32'h14);
    checks++;
    if (bus.mem_data !== 32'd0 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL sw_x0: got data=%h we=%b addr=%h want 0/1/0", bus.mem_data, bus.mem_we,
               bus.mem_addr);
    end
  endtask

  task automatic test_branch_plan();
    apply(enc_b(16, 1, 2, 4), 32'h100);
    checks++;
    if (bus.branch_taken !== 1'b1 || bus.branch_target !== 32'h110) begin
      failures++;
      $display("FAIL blt: got %b/%h want 1/00000110", bus.branch_taken, bus.branch_target);
    end
    apply(enc_b(16, 1, 2, 5), 32'h100);
    checks++;
    if (bus.branch_taken !== 1'b0) begin
      failures++; $display("FAIL bge: got %b want 0", bus.branch_taken);
    end
    apply(enc_b(-8, 1, 1, 0), 32'h100);
    checks++;
    if (bus.branch_taken !== 1'b1 || bus.branch_target !== 32'hF8) begin
      failures++;
      $display("FAIL beq_back: got %b/%h want 1/000000f8", bus.branch_taken, bus.branch_target);
    end
    apply(enc_b(-8, 2, 1, 1), 32'h100);
    checks++;
    if (bus.branch_taken !== 1'b1 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL bne: got %b/%b want 1/0", bus.branch_taken, bus.mem_we);
    end
  endtask

  task automatic test_jumps();
    apply(enc_j(32'h20, 1), 32'h40);
    checks++;
    if (bus.branch_taken !== 1'b1 || bus.branch_target !== 32'h60) begin
      failures++;
      $display("FAIL jal: got %b/%h want 1/00000060", bus.branch_taken, bus.branch_target);
    end
    tick();
    apply(enc_s(0, 1, 0), 32'h60);
    checks++;
    if (bus.mem_data !== 32'h44) begin
      failures++; $display("FAIL jal_link: got %h want 00000044", bus.mem_data);
    end
    apply(enc_i(3, 1, 0, 5, 7'b1100111), 32'h80);
    checks++;
    if (bus.branch_taken !== 1'b1 || bus.branch_target !== 32'h46) begin
      failures++;
      $display("FAIL jalr: got %b/%h want 1/00000046", bus.branch_taken, bus.branch_target);
    end
    tick();
    apply(enc_s(0, 5, 0), 32'h84);
    checks++;
    if (bus.mem_data !== 32'h84) begin
      failures++; $display("FAIL jalr_link: got %h want 00000084", bus.mem_data);
    end
  endtask

  task automatic test_async_reset();
    apply(enc_i(9, 0, 0, 7, 7'b0010011), 32'h0); tick();
    apply(enc_s(0, 7, 0), 32'h4);
    checks++;
    if (bus.mem_data !== 32'd9) begin
      failures++; $display("FAIL x7_written: got %h want 9", bus.mem_data);
    end
    #2;
    do_reset(1'b1);
    #1;
    checks++;
    if (bus.mem_data !== 32'd0) begin
      failures++; $display("FAIL async_clear: got %h want 0", bus.mem_data);
    end
    apply(enc_i(11, 0, 0, 7, 7'b0010011), 32'h8);
    tick();
    do_reset(1'b0);
    apply(enc_s(0, 7, 0), 32'hC);
    checks++;
    if (bus.mem_data !== 32'd0) begin
      failures++; $display("FAIL pending_discarded: got %h want 0", bus.mem_data);
    end
    apply(enc_i(11, 0, 0, 7, 7'b0010011), 32'h10); tick();
    apply(enc_s(0, 7, 0), 32'h14);
    checks++;
    if (bus.mem_data !== 32'd11) begin
      failures++; $display("FAIL first_write_after_reset: got %h want 0000000b", bus.mem_data);
    end
  endtask

  task automatic test_undefined();
    apply(32'h0000_007F, 32'h20);
    checks++;
    if (bus.branch_taken !== 1'b0 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL undef_strobes: got %b/%b want 0/0", bus.branch_taken, bus.mem_we);
    end
    apply(enc_s(0, 7, 0), 32'h24);
    apply(32'h0000_007F | (32'd7 << 7), 32'h28);  // rd=x7 on undefined opcode
    tick();
    apply(enc_s(0, 7, 0), 32'h2C);
    checks++;
    if (bus.mem_data !== 32'd11) begin
      failures++; $display("FAIL undef_no_write: got %h want 0000000b", bus.mem_data);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0100011; ops[3] = 7'b1100011;
    ops[4] = 7'b1101111; ops[5] = 7'b1100111; ops[6] = 7'b0001111;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins, pcv;
      exp_t        e;
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 6)];
      ins[11:10] = 2'b00; ins[19:18] = 2'b00; ins[24:23] = 2'b00;  // regs x0..x7
      if (ins[6:0] == 7'b0100011 && $urandom_range(0, 3) != 0) ins[14:12] = 3'b010;
      if (ins[6:0] == 7'b1100111 && $urandom_range(0, 3) != 0) ins[14:12] = 3'b000;
      pcv = $urandom & 32'hFFFF_FFFC;
      apply(ins, pcv);
      e = model_eval(ins, pcv);
      checks++;
      if (bus.branch_taken !== e.taken || bus.mem_we !== e.we || bus.mem_data !== e.data) begin
        failures++;
        $display("FAIL rand_ctl ins=%h: got taken=%b we=%b data=%h want %b %b %h", ins,
                 bus.branch_taken, bus.mem_we, bus.mem_data, e.taken, e.we, e.data);
      end
      if (e.chk_addr) begin
        checks++;
        if (bus.mem_addr !== e.addr) begin
          failures++;
          $display("FAIL rand_addr ins=%h: got %h want %h", ins, bus.mem_addr, e.addr);
        end
      end
      if (e.chk_target) begin
        checks++;
        if (bus.branch_target !== e.target) begin
          failures++;
          $display("FAIL rand_target ins=%h: got %h want %h", ins, bus.branch_target, e.target);
        end
      end
      tick();
    end
    for (int k = 0; k < 32; k++) begin
      apply(enc_s(0, k, 0), 32'h0);
      checks++;
      if (bus.mem_data !== regs[k]) begin
        failures++; $display("FAIL rand_regdump x%0d: got %h want %h", k, bus.mem_data, regs[k]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.instr = '0;
    bus.pc    = '0;
    do_reset(1'b1);
    test_reset();
    test_alu_plan();
    test_branch_plan();
    test_jumps();
    test_async_reset();
    test_undefined();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
